// File: rtl/mem_responder.sv
// mem_responder: far end of the CPU byte-wide load/store port.
//
// Holds a synchronous byte RAM with one-cycle read latency and decodes an I/O window
// (mem_a[17:16] == 2'b11) containing a transmit FIFO (0x30000), a halt register (0x30004)
// and an optional 32-bit cycle counter read through 0x30004..0x30007.
//
// Optional feature: define MEM_RESP_COUNTER_EN to build the cycle counter and its snapshot
// register. Without it, counter reads return 8'h00 and a halt write still pulses sim_done.
//
// rdy_in low freezes every register in the block, including RAM writes and FIFO pops.

module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_WIDTH = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready,
    output logic        sim_done,
    output logic        fifo_overflow
);

    localparam int unsigned RamBytes = 2 ** ADDR_WIDTH;

    // FIFO depth expressed in the count register's width
    localparam logic [FIFO_WIDTH:0] DepthCnt = (FIFO_WIDTH + 1)'(FIFO_DEPTH);

    // I/O window offsets, compared against mem_a[17:0]
    localparam logic [17:0] IoTxAddr   = 18'h30000;
    localparam logic [17:0] IoHaltAddr = 18'h30004;
    localparam logic [17:0] IoCnt1Addr = 18'h30005;
    localparam logic [17:0] IoCnt2Addr = 18'h30006;
    localparam logic [17:0] IoCnt3Addr = 18'h30007;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0] ram [RamBytes];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [7:0]            mem_din_q;
    logic                  buffer_full_q;
    logic                  sim_done_q;
    logic                  overflow_q;
    logic [FIFO_WIDTH-1:0] wr_ptr_q;
    logic [FIFO_WIDTH-1:0] rd_ptr_q;
    logic [FIFO_WIDTH:0]   count_q;
    logic [FIFO_WIDTH:0]   count_d;

`ifdef MEM_RESP_COUNTER_EN
    logic [31:0] counter_q;
    logic [31:0] snapshot_q;
`endif

    // ------------------------------------------------------------------
    // Address decode and access strobes
    // ------------------------------------------------------------------
    logic                  is_io;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [17:0]           io_off;
    logic                  ram_we;
    logic                  tx_push;
    logic                  halt_wr;
    logic                  snap_load;
    logic                  unused_addr_bits;

    // Upper address bits carry no meaning for this responder
    assign unused_addr_bits = ^mem_a[31:18];

    // Classify the current access; every strobe already includes rdy_in
    always_comb begin
        is_io     = (mem_a[17:16] == 2'b11);
        ram_addr  = mem_a[ADDR_WIDTH-1:0];
        io_off    = mem_a[17:0];
        ram_we    = rdy_in && !is_io && mem_wr;
        tx_push   = rdy_in && is_io && mem_wr && (io_off == IoTxAddr);
        halt_wr   = rdy_in && is_io && mem_wr && (io_off == IoHaltAddr);
        snap_load = rdy_in && is_io && !mem_wr && (io_off == IoHaltAddr);
    end

    // ------------------------------------------------------------------
    // I/O read data
    // ------------------------------------------------------------------
    logic [7:0] io_rd_data;

    // Select the byte returned for an I/O read; unmapped offsets read as zero
    always_comb begin
        io_rd_data = 8'h00;
`ifdef MEM_RESP_COUNTER_EN
        // Byte 0 comes straight from the live counter while the snapshot is
        // loaded, so bytes 1..3 read afterwards belong to the same 32-bit word.
        case (io_off)
            IoHaltAddr: io_rd_data = counter_q[7:0];
            IoCnt1Addr: io_rd_data = snapshot_q[15:8];
            IoCnt2Addr: io_rd_data = snapshot_q[23:16];
            IoCnt3Addr: io_rd_data = snapshot_q[31:24];
            default:    io_rd_data = 8'h00;
        endcase
`endif
    end

    // ------------------------------------------------------------------
    // Transmit FIFO control
    // ------------------------------------------------------------------
    logic fifo_full;
    logic fifo_pop;
    logic fifo_push_ok;
    logic fifo_drop;

    assign io_tx_valid = (count_q != '0);

    // Head byte is forced to zero while empty so reset shows a clean bus
    assign io_tx_data = io_tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;

    // Push/pop arbitration; a pop in the same cycle frees the slot a full push needs
    always_comb begin
        fifo_full    = (count_q == DepthCnt);
        fifo_pop     = rdy_in && io_tx_valid && io_tx_ready;
        fifo_push_ok = tx_push && (!fifo_full || fifo_pop);
        fifo_drop    = tx_push && fifo_full && !fifo_pop;
        count_d      = count_q;
        if (fifo_push_ok && !fifo_pop) begin
            count_d = count_q + 1'b1;
        end else if (!fifo_push_ok && fifo_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO data array; at full the write slot equals the head being popped
    always_ff @(posedge clk_in) begin
        if (fifo_push_ok) begin
            fifo_mem[wr_ptr_q] <= mem_dout;
        end
    end

    // FIFO pointers, occupancy, near-full flag and sticky overflow
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            buffer_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (rdy_in) begin
            if (fifo_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            // One slot of margin: the CPU only sees this flag a cycle late
            buffer_full_q <= (count_d >= DepthCnt - 1'b1);
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM and read-data register
    // ------------------------------------------------------------------

    // RAM write port; contents are intentionally left out of reset
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    // Registered read data; write cycles leave the previous value in place
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din_q <= 8'h00;
        end else if (rdy_in && !mem_wr) begin
            mem_din_q <= is_io ? io_rd_data : ram[ram_addr];
        end
    end

    // ------------------------------------------------------------------
    // Halt pulse
    // ------------------------------------------------------------------

    // One active cycle per halt write; stretches naturally while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sim_done_q <= 1'b0;
        end else if (rdy_in) begin
            sim_done_q <= halt_wr;
        end
    end

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
`ifdef MEM_RESP_COUNTER_EN
    // Free-running counter of enabled cycles plus the snapshot taken on a byte-0 read
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            counter_q  <= 32'h0000_0000;
            snapshot_q <= 32'h0000_0000;
        end else if (rdy_in) begin
            counter_q <= counter_q + 32'd1;
            if (snap_load) begin
                snapshot_q <= counter_q;
            end
        end
    end
`else
    logic unused_snap_load;
    assign unused_snap_load = snap_load;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_din        = mem_din_q;
    assign io_buffer_full = buffer_full_q;
    assign sim_done       = sim_done_q;
    assign fifo_overflow  = overflow_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed stimulus for mem_responder, checked every cycle
// against a transaction-level model (associative-array RAM, queue FIFO, plain cycle count).
// Define MEM_RESP_COUNTER_EN for both files to exercise the counter build.

module tb_mem_responder;

    localparam int unsigned DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] mem_a = 32'h0003_00F0;
    logic [7:0]  mem_dout = 8'h00;
    logic        mem_wr = 1'b1;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready = 1'b0;
    logic        sim_done;
    logic        fifo_overflow;

    always #5 clk_in = ~clk_in;

    mem_responder dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_a         (mem_a),
        .mem_dout      (mem_dout),
        .mem_wr        (mem_wr),
        .mem_din       (mem_din),
        .io_buffer_full(io_buffer_full),
        .io_tx_data    (io_tx_data),
        .io_tx_valid   (io_tx_valid),
        .io_tx_ready   (io_tx_ready),
        .sim_done      (sim_done),
        .fifo_overflow (fifo_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: state predicted for after the next rising edge
    // ------------------------------------------------------------------
    logic [7:0]  m_ram [int];
    logic [7:0]  m_fifo [$];
    logic [7:0]  m_din;
    bit          m_din_known;
    bit          m_full;
    bit          m_done;
    bit          m_ovf;
    logic [31:0] m_cnt;
    logic [31:0] m_snap;

    task automatic model_reset();
        m_fifo.delete();
        m_din       = 8'h00;
        m_din_known = 1'b1;
        m_full      = 1'b0;
        m_done      = 1'b0;
        m_ovf       = 1'b0;
        m_cnt       = 32'd0;
        m_snap      = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] a;
        int          addr;
        int          sz;
        bit          push;
        bit          pop;
        a = mem_a;
        if (!rdy_in) return;
        push   = 1'b0;
        m_done = 1'b0;
        if (a[17:16] != 2'b11) begin
            addr = int'(a[16:0]);
            if (mem_wr) begin
                m_ram[addr] = mem_dout;
            end else if (m_ram.exists(addr)) begin
                m_din = m_ram[addr];
                m_din_known = 1'b1;
            end else begin
                m_din_known = 1'b0;
            end
        end else if (mem_wr) begin
            if (a[17:0] == 18'h30000) push = 1'b1;
            if (a[17:0] == 18'h30004) m_done = 1'b1;
        end else begin
            m_din = 8'h00;
            m_din_known = 1'b1;
`ifdef MEM_RESP_COUNTER_EN
            case (a[17:0])
                18'h30004: begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
                18'h30005: m_din = m_snap[15:8];
                18'h30006: m_din = m_snap[23:16];
                18'h30007: m_din = m_snap[31:24];
                default: ;
            endcase
`endif
        end
        sz  = m_fifo.size();
        pop = (sz > 0) && io_tx_ready;
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (sz == DEPTH && !pop) m_ovf = 1'b1;
            else m_fifo.push_back(mem_dout);
        end
        m_full = (m_fifo.size() >= DEPTH - 1);
        m_cnt  = m_cnt + 32'd1;
    endtask

    // Compare process: check outputs on every falling edge, then advance the model
    initial begin
        model_reset();
        forever begin
            @(negedge clk_in);
            if (!rst_in) model_reset();
            if (m_din_known) chk("mem_din", mem_din, m_din);
            chk("io_buffer_full", io_buffer_full, m_full);
            chk("io_tx_valid", io_tx_valid, m_fifo.size() != 0);
            chk("io_tx_data", io_tx_data, (m_fifo.size() != 0) ? m_fifo[0] : 8'h00);
            chk("sim_done", sim_done, m_done);
            chk("fifo_overflow", fifo_overflow, m_ovf);
            if (rst_in) model_step();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic wr);
        @(posedge clk_in);
        #1;
        mem_a    = a;
        mem_dout = d;
        mem_wr   = wr;
    endtask

    // Write to an unmapped I/O offset: touches nothing
    task automatic idle();
        drive(32'h0003_00F0, 8'h00, 1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stim
        logic [7:0]  seq [4];
        logic [7:0]  drain [8];
        int          pool [32];
        logic [31:0] a;
        logic [31:0] up;
        int          r;

        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        for (int i = 0; i < 32; i++) pool[i] = (i < 16) ? i : 32'h1FFF0 + i - 16;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_tx_valid", io_tx_valid, 1'b0);
        chk("rst_tx_data", io_tx_data, 8'h00);
        chk("rst_full", io_buffer_full, 1'b0);
        chk("rst_done", sim_done, 1'b0);
        chk("rst_ovf", fifo_overflow, 1'b0);
        rst_in = 1'b1;

        // Write then read back
        drive(32'h0000_0010, 8'hA5, 1'b1);
        drive(32'h0000_0010, 8'h00, 1'b0);
        idle();
        chk("ram_a5", mem_din, 8'hA5);

        // Back-to-back reads with one cycle of lag
        for (int i = 0; i < 4; i++) drive(i, seq[i], 1'b1);
        drive(32'h0, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) drive(i, 8'h00, 1'b0);
            else idle();
            chk("ram_seq", mem_din, seq[i-1]);
        end

        // Fill FIFO with the consumer stalled
        io_tx_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            drive(32'h0003_0000, 8'(k), 1'b1);
            idle();
            chk("fill_full", io_buffer_full, k >= 7);
        end
        chk("fill_head", io_tx_data, 8'h01);

        // Push and pop together at full: no drop
        drive(32'h0003_0000, 8'h5A, 1'b1);
        io_tx_ready = 1'b1;
        idle();
        io_tx_ready = 1'b0;
        chk("pp_ovf", fifo_overflow, 1'b0);
        chk("pp_full", io_buffer_full, 1'b1);
        chk("pp_head", io_tx_data, 8'h02);

        // Push at full without pop is dropped
        drive(32'h0003_0000, 8'h99, 1'b1);
        idle();
        chk("drop_ovf", fifo_overflow, 1'b1);

        // Drain in order
        for (int j = 0; j < 8; j++) drain[j] = (j < 7) ? 8'(j + 2) : 8'h5A;
        io_tx_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("drain_data", io_tx_data, drain[j]);
            idle();
        end
        chk("drain_empty", io_tx_valid, 1'b0);
        io_tx_ready = 1'b0;

        // Halt pulse, plain and stretched by a stall
        drive(32'h0003_0004, 8'hFF, 1'b1);
        idle();
        chk("halt_hi", sim_done, 1'b1);
        idle();
        chk("halt_lo", sim_done, 1'b0);
        drive(32'h0003_0004, 8'h00, 1'b1);
        idle();
        rdy_in = 1'b0;
        idle();
        idle();
        chk("halt_stall", sim_done, 1'b1);
        rdy_in = 1'b1;
        idle();
        chk("halt_end", sim_done, 1'b0);

        // Reset mid-drain
        for (int k = 0; k < 3; k++) drive(32'h0003_0000, 8'hC0 + 8'(k), 1'b1);
        io_tx_ready = 1'b1;
        idle();
        rst_in = 1'b0;
        #1;
        chk("mid_rst_valid", io_tx_valid, 1'b0);
        chk("mid_rst_data", io_tx_data, 8'h00);
        idle();
        idle();
        rst_in = 1'b1;
        io_tx_ready = 1'b0;
        drive(32'h0000_0010, 8'h00, 1'b0);
        idle();
        chk("ram_after_rst", mem_din, 8'hA5);

        // Counter read about 300 cycles after reset
        idle();
        rst_in = 1'b0;
        idle();
        rst_in = 1'b1;
        repeat (300) idle();
        drive(32'h0003_0004, 8'h00, 1'b0);
        drive(32'h0003_0005, 8'h00, 1'b0);
`ifdef MEM_RESP_COUNTER_EN
        chk("cnt_b0", mem_din, 8'h2D);
`else
        chk("cnt_b0", mem_din, 8'h00);
`endif
        drive(32'h0003_0006, 8'h00, 1'b0);
`ifdef MEM_RESP_COUNTER_EN
        chk("cnt_b1", mem_din, 8'h01);
`else
        chk("cnt_b1", mem_din, 8'h00);
`endif
        drive(32'h0003_0007, 8'h00, 1'b0);
        chk("cnt_b2", mem_din, 8'h00);
        idle();
        chk("cnt_b3", mem_din, 8'h00);

        // Seed the RAM pool so every random read has a known value
        for (int i = 0; i < 32; i++) drive(pool[i], 8'($urandom), 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_in);
            #1;
            if (i == 1500) rst_in = 1'b0;
            if (i == 1503) rst_in = 1'b1;
            r  = $urandom_range(0, 99);
            up = $urandom();
            if (r < 30) begin
                a = (up & 32'hFFFC_0000) | pool[$urandom_range(0, 31)];
                mem_wr = 1'($urandom_range(0, 1));
            end else if (r < 55) begin
                a = 32'h0003_0000;
                mem_wr = 1'b1;
            end else if (r < 60) begin
                a = 32'h0003_0004;
                mem_wr = 1'b1;
            end else if (r < 80) begin
                a = 32'h0003_0000 + $urandom_range(0, 8);
                mem_wr = 1'b0;
            end else begin
                a = 32'h0003_00F0;
                mem_wr = 1'($urandom_range(0, 1));
            end
            mem_a       = a;
            mem_dout    = 8'($urandom);
            rdy_in      = ($urandom_range(0, 9) != 0);
            io_tx_ready = ($urandom_range(0, 2) == 0);
        end

        rdy_in = 1'b1;
        repeat (4) idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
